// File: rtl/mem_bus_sched.sv
// mem_bus_sched: two-port scheduler for the byte-wide RAM/IO bus.
// Data port has fixed priority over instruction fetch; an open transaction
// is never preempted. 1/2/4-byte accesses are serialised little-endian.
// Optional one-entry fetch buffer: define MEM_SCHED_IBUF_EN.
module mem_bus_sched #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    // instruction fetch port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic              i_done,
    output logic [31:0]       i_rdata,
    // data load/store port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [2:0]        d_len,
    input  logic [31:0]       d_wdata,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    // byte bus
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state;
    logic              gnt_d;      // 1: data port owns the transaction
    logic              is_wr;      // latched d_we of the granted data access
    logic [ADDR_W-1:0] base;
    logic [2:0]        n;          // byte count
    logic [2:0]        k;          // issue index
    logic [2:0]        c;          // capture index
    logic              iss_vld;    // previous cycle issued byte c
    logic [31:0]       wbuf;
    logic [31:0]       rbuf;       // read assembly, zero-extended
    logic [31:0]       i_rdata_q;
    logic [31:0]       d_rdata_q;

`ifdef MEM_SCHED_IBUF_EN
    logic              ib_valid;
    logic [ADDR_W-1:0] ib_addr;
    logic [31:0]       ib_word;
`endif

    logic io_hold;
    logic wr_act;

    // UART writes stall while the TX buffer is full (IO space is base[17:16]==3)
    assign io_hold = (state == WR) && (base[17:16] == 2'b11) && io_buffer_full;
    assign wr_act  = (state == WR) && !io_hold;

    // Done pulses are gated by rdy_in so a frozen DONE still yields one pulse;
    // a flush in DONE swallows the fetch completion.
    assign i_done  = rdy_in && (state == DONE) && !gnt_d && !i_flush;
    assign d_done  = rdy_in && (state == DONE) && gnt_d;

    // Read data is presented straight from the assembly buffer on the done
    // cycle and held afterwards until the next completion of that port.
    assign i_rdata = i_done ? rbuf : i_rdata_q;
    assign d_rdata = (d_done && !is_wr) ? rbuf : d_rdata_q;

    // Bus drive: address/data only while reading or actively writing
    always_comb begin
        mem_a    = '0;
        mem_dout = '0;
        mem_wr   = 1'b0;
        if (wr_act) begin
            mem_a    = base + ADDR_W'(k);
            mem_dout = wbuf[{k[1:0], 3'b000} +: 8];
            mem_wr   = rdy_in;
        end else if ((state == RD) && (k < n)) begin
            mem_a    = base + ADDR_W'(k);
        end
    end

    // Scheduler FSM, byte sequencing and result registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= IDLE;
            gnt_d     <= 1'b0;
            is_wr     <= 1'b0;
            base      <= '0;
            n         <= '0;
            k         <= '0;
            c         <= '0;
            iss_vld   <= 1'b0;
            wbuf      <= '0;
            rbuf      <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef MEM_SCHED_IBUF_EN
            ib_valid  <= 1'b0;
            ib_addr   <= '0;
            ib_word   <= '0;
`endif
        end else if (!rdy_in) begin
            // Frozen: the in-flight byte is lost, so re-issue from the
            // first uncaptured index once ready returns.
            if (state == RD) k <= c;
            iss_vld <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    k       <= '0;
                    c       <= '0;
                    iss_vld <= 1'b0;
                    rbuf    <= '0;
                    if (d_req) begin
                        gnt_d <= 1'b1;
                        is_wr <= d_we;
                        base  <= d_addr;
                        n     <= d_len;
                        wbuf  <= d_wdata;
                        state <= d_we ? WR : RD;
                    end else if (i_req && !i_flush) begin
                        gnt_d <= 1'b0;
                        is_wr <= 1'b0;
                        base  <= i_addr;
                        n     <= 3'd4;
`ifdef MEM_SCHED_IBUF_EN
                        if (ib_valid && (ib_addr == i_addr)) begin
                            rbuf  <= ib_word;
                            state <= DONE;
                        end else begin
                            state <= RD;
                        end
`else
                        state <= RD;
`endif
                    end
                end
                RD: begin
                    if (!gnt_d && i_flush) begin
                        iss_vld <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        iss_vld <= (k < n);
                        if (k < n) k <= k + 3'd1;
                        if (iss_vld) begin
                            rbuf[{c[1:0], 3'b000} +: 8] <= mem_din;
                            c <= c + 3'd1;
                            if (c + 3'd1 == n) state <= DONE;
                        end
                    end
                end
                WR: begin
                    if (!io_hold) begin
                        k <= k + 3'd1;
                        if (k + 3'd1 == n) begin
                            state <= DONE;
`ifdef MEM_SCHED_IBUF_EN
                            // a store into the buffered word makes it stale
                            if (base[ADDR_W-1:2] == ib_addr[ADDR_W-1:2]) ib_valid <= 1'b0;
`endif
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (i_done) begin
                        i_rdata_q <= rbuf;
`ifdef MEM_SCHED_IBUF_EN
                        ib_valid  <= 1'b1;
                        ib_addr   <= base;
                        ib_word   <= rbuf;
`endif
                    end
                    if (d_done && !is_wr) d_rdata_q <= rbuf;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
